tq_recon_4x4: RTL and testbench

Reconstruction stage directly downstream of the inverse-transform/dequant stage. It takes one 4x4 residual block plus the matching 4x4 prediction block, and forms each reconstructed pixel as clip(pred + rounded residual). It then writes the block row-by-row into the 16x16 macroblock reconstruction buffer. The block runs in z-scan order and counts 16 blocks per macroblock.

---
 rtl/tq_recon_pkg.sv | 23 ++
 rtl/tq_clip_add.sv | 54 +++++
 rtl/tq_recon_4x4.sv | 170 +++++++++++++++++
 tb/tb_tq_recon_4x4.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tq_recon_pkg.sv
// -----------------------------------------------------------------------------
// tq_recon_pkg
// Shared types and helpers for the 4x4 reconstruction stage: default sample
// widths, pixel/row types, the emit FSM state encoding and the z-scan block
// position decoder.
// -----------------------------------------------------------------------------
package tq_recon_pkg;

  localparam int PIX_W_DEF       = 8;
  localparam int RES_W_DEF       = 15;
  localparam int ROUND_SHIFT_DEF = 6;

  typedef logic [7:0]  pix_t;
  typedef logic [31:0] row_t;

  typedef enum logic {IDLE, EMIT} state_t;

  // Z-scan block index -> {y4, x4}. Even index bits give x, odd bits give y.
  function automatic logic [3:0] zscan_xy(input logic [3:0] blk);
    return {blk[3], blk[1], blk[2], blk[0]};
  endfunction

endpackage

// File: rtl/tq_clip_add.sv
// -----------------------------------------------------------------------------
// tq_clip_add
// One reconstructed pixel: round the residual by ROUND_SHIFT (floor shift after
// adding half an LSB), add the prediction and clip to the unsigned pixel range.
// Purely combinational.
//   i_res  : signed residual sample
//   i_pred : unsigned prediction pixel
//   o_pix  : clip(pred + rounded residual)
// -----------------------------------------------------------------------------
module tq_clip_add
  import tq_recon_pkg::*;
#(
  parameter int RES_W       = RES_W_DEF,
  parameter int PIX_W       = PIX_W_DEF,
  parameter int ROUND_SHIFT = ROUND_SHIFT_DEF
) (
  input  logic signed [RES_W-1:0] i_res,
  input  logic        [PIX_W-1:0] i_pred,
  output logic        [PIX_W-1:0] o_pix
);

  // Two guard bits: one for the rounding add, one for the prediction add.
  localparam int SW = RES_W + 2;
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

  logic signed [SW-1:0] w_res_ext;
  logic signed [SW-1:0] w_r;
  logic signed [SW-1:0] w_sum;

  assign w_res_ext = {{2{i_res[RES_W-1]}}, i_res};

  generate
    if (ROUND_SHIFT > 0) begin : g_round
      localparam logic signed [SW-1:0] RND = SW'(2 ** (ROUND_SHIFT - 1));
      assign w_r = (w_res_ext + RND) >>> ROUND_SHIFT;
    end else begin : g_pass
      assign w_r = w_res_ext;
    end
  endgenerate

  assign w_sum = w_r + $signed({{(SW - PIX_W){1'b0}}, i_pred});

  // NOTE: every branch assigns o_pix, so no latch is inferred.
  always_comb begin
    if (w_sum[SW-1]) begin
      o_pix = '0;
    end else if (w_sum > PIX_MAX) begin
      o_pix = '1;
    end else begin
      o_pix = w_sum[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/tq_recon_4x4.sv
// -----------------------------------------------------------------------------
// tq_recon_4x4
// Reconstructs a 4x4 block (clip(pred + rounded residual)) and writes it
// row-by-row into the 16x16 macroblock buffer, blocks taken in z-scan order.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   mb_start_i              : abort in-flight block, restart block count
//   in_valid_i/in_ready_o   : block handshake (in_ready_o is combinational
//                             from wr_ready_i to allow back-to-back blocks)
//   res_iRC_i / pred_iRC_i  : residual / prediction, row R, column C
//   wr_valid_o/wr_ready_i   : buffer write handshake
//   wr_addr_o               : {y4, row, x4} word address
//   wr_data_o               : one row, column C at bits [8C+7:8C]
//   blk_cnt_o               : z-scan index of the next block to be written
//   mb_done_o               : pulse after the 16th block's last row is written
// -----------------------------------------------------------------------------
module tq_recon_4x4
  import tq_recon_pkg::*;
#(
  parameter int RES_W       = RES_W_DEF,
  parameter int PIX_W       = PIX_W_DEF,
  parameter int ROUND_SHIFT = ROUND_SHIFT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mb_start_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [RES_W-1:0] res_i00_i, res_i01_i, res_i02_i, res_i03_i,
  input  logic signed [RES_W-1:0] res_i10_i, res_i11_i, res_i12_i, res_i13_i,
  input  logic signed [RES_W-1:0] res_i20_i, res_i21_i, res_i22_i, res_i23_i,
  input  logic signed [RES_W-1:0] res_i30_i, res_i31_i, res_i32_i, res_i33_i,
  input  logic        [PIX_W-1:0] pred_i00_i, pred_i01_i, pred_i02_i, pred_i03_i,
  input  logic        [PIX_W-1:0] pred_i10_i, pred_i11_i, pred_i12_i, pred_i13_i,
  input  logic        [PIX_W-1:0] pred_i20_i, pred_i21_i, pred_i22_i, pred_i23_i,
  input  logic        [PIX_W-1:0] pred_i30_i, pred_i31_i, pred_i32_i, pred_i33_i,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic [5:0]              wr_addr_o,
  output logic [4*PIX_W-1:0]      wr_data_o,
  output logic [3:0]              blk_cnt_o,
  output logic                    mb_done_o
);

  logic signed [RES_W-1:0] w_res  [16];
  logic        [PIX_W-1:0] w_pred [16];
  logic        [PIX_W-1:0] w_pix  [16];
  logic      [4*PIX_W-1:0] w_row  [4];

  assign w_res  = '{res_i00_i, res_i01_i, res_i02_i, res_i03_i,
                    res_i10_i, res_i11_i, res_i12_i, res_i13_i,
                    res_i20_i, res_i21_i, res_i22_i, res_i23_i,
                    res_i30_i, res_i31_i, res_i32_i, res_i33_i};
  assign w_pred = '{pred_i00_i, pred_i01_i, pred_i02_i, pred_i03_i,
                    pred_i10_i, pred_i11_i, pred_i12_i, pred_i13_i,
                    pred_i20_i, pred_i21_i, pred_i22_i, pred_i23_i,
                    pred_i30_i, pred_i31_i, pred_i32_i, pred_i33_i};

  generate
    for (genvar p = 0; p < 16; p++) begin : g_pix
      tq_clip_add #(
        .RES_W      (RES_W),
        .PIX_W      (PIX_W),
        .ROUND_SHIFT(ROUND_SHIFT)
      ) u_clip (
        .i_res (w_res[p]),
        .i_pred(w_pred[p]),
        .o_pix (w_pix[p])
      );
    end
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_row[r] = {w_pix[4*r+3], w_pix[4*r+2], w_pix[4*r+1], w_pix[4*r]};
    end
  endgenerate

  function automatic logic [5:0] row_addr(input logic [3:0] blk, input logic [1:0] row);
    logic [3:0] xy;
    xy = zscan_xy(blk);
    return {xy[3:2], row, xy[1:0]};
  endfunction

  state_t             r_state;
  logic [1:0]         r_row_cnt;
  logic [3:0]         r_blk_cnt;
  logic               r_wr_valid;
  logic [5:0]         r_wr_addr;
  logic [4*PIX_W-1:0] r_wr_data;
  logic               r_mb_done;
  logic [4*PIX_W-1:0] r_hold [4];

  logic       w_row_last;
  logic       w_accept;
  logic [3:0] w_blk_next;
  logic [1:0] w_row_next;

  assign w_row_last = (r_row_cnt == 2'd3);
  assign w_blk_next = r_blk_cnt + 4'd1;
  assign w_row_next = r_row_cnt + 2'd1;

  // A new block may enter while the last row of the current one is written.
  assign in_ready_o = !mb_start_i &&
                      ((r_state == IDLE) || ((r_state == EMIT) && w_row_last && wr_ready_i));
  assign w_accept   = in_valid_i && in_ready_o;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_row_cnt  <= 2'd0;
      r_blk_cnt  <= 4'd0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_mb_done  <= 1'b0;
      // NOTE: the hold rows are a handful of flops, cleared on reset so no
      // stale pixels from before reset can appear on the write bus.
      for (int i = 0; i < 4; i++) r_hold[i] <= '0;
    end else begin
      r_mb_done <= 1'b0;
      if (mb_start_i) begin
        r_state    <= IDLE;
        r_wr_valid <= 1'b0;
        r_blk_cnt  <= 4'd0;
        r_row_cnt  <= 2'd0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_hold     <= w_row;
              r_row_cnt  <= 2'd0;
              r_state    <= EMIT;
              r_wr_valid <= 1'b1;
              r_wr_addr  <= row_addr(r_blk_cnt, 2'd0);
              r_wr_data  <= w_row[0];
            end
          end
          EMIT: begin
            if (wr_ready_i) begin
              if (w_row_last) begin
                r_blk_cnt <= w_blk_next;
                if (r_blk_cnt == 4'd15) r_mb_done <= 1'b1;
                if (w_accept) begin
                  r_hold    <= w_row;
                  r_row_cnt <= 2'd0;
                  r_wr_addr <= row_addr(w_blk_next, 2'd0);
                  r_wr_data <= w_row[0];
                end else begin
                  r_state    <= IDLE;
                  r_wr_valid <= 1'b0;
                end
              end else begin
                r_row_cnt <= w_row_next;
                r_wr_addr <= row_addr(r_blk_cnt, w_row_next);
                r_wr_data <= r_hold[w_row_next];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign blk_cnt_o  = r_blk_cnt;
  assign mb_done_o  = r_mb_done;

endmodule

// File: tb/tb_tq_recon_4x4.sv
// -----------------------------------------------------------------------------
// tb_tq_recon_4x4
// Directed-vector bench for tq_recon_4x4: reset, single block, clipping,
// write backpressure, a full back-to-back macroblock and an abort.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_tq_recon_4x4;
  import tq_recon_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               mb_start_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic signed [14:0] res_a  [16];
  logic        [7:0]  pred_a [16];
  logic               wr_valid_o;
  logic               wr_ready_i;
  logic [5:0]         wr_addr_o;
  logic [31:0]        wr_data_o;
  logic [3:0]         blk_cnt_o;
  logic               mb_done_o;

  int n_vec = 0;
  int n_err = 0;

  // Row-0 word address of each z-scan block, worked out by hand.
  logic [5:0] base_addr [16] = '{6'd0, 6'd1, 6'd16, 6'd17, 6'd2, 6'd3, 6'd18, 6'd19,
                                 6'd32, 6'd33, 6'd48, 6'd49, 6'd34, 6'd35, 6'd50, 6'd51};

  always #5 clk_i = ~clk_i;

  tq_recon_4x4 dut (
    .clk_i(clk_i), .rst_i(rst_i), .mb_start_i(mb_start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .res_i00_i(res_a[0]),  .res_i01_i(res_a[1]),  .res_i02_i(res_a[2]),  .res_i03_i(res_a[3]),
    .res_i10_i(res_a[4]),  .res_i11_i(res_a[5]),  .res_i12_i(res_a[6]),  .res_i13_i(res_a[7]),
    .res_i20_i(res_a[8]),  .res_i21_i(res_a[9]),  .res_i22_i(res_a[10]), .res_i23_i(res_a[11]),
    .res_i30_i(res_a[12]), .res_i31_i(res_a[13]), .res_i32_i(res_a[14]), .res_i33_i(res_a[15]),
    .pred_i00_i(pred_a[0]),  .pred_i01_i(pred_a[1]),  .pred_i02_i(pred_a[2]),  .pred_i03_i(pred_a[3]),
    .pred_i10_i(pred_a[4]),  .pred_i11_i(pred_a[5]),  .pred_i12_i(pred_a[6]),  .pred_i13_i(pred_a[7]),
    .pred_i20_i(pred_a[8]),  .pred_i21_i(pred_a[9]),  .pred_i22_i(pred_a[10]), .pred_i23_i(pred_a[11]),
    .pred_i30_i(pred_a[12]), .pred_i31_i(pred_a[13]), .pred_i32_i(pred_a[14]), .pred_i33_i(pred_a[15]),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .blk_cnt_o(blk_cnt_o), .mb_done_o(mb_done_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill(input int p, input int r);
    for (int i = 0; i < 16; i++) begin
      pred_a[i] = 8'(p);
      res_a[i]  = 15'(r);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mb_start_i = 1'b0; in_valid_i = 1'b0; wr_ready_i = 1'b1;
    fill(0, 0);
    tick(); tick();
    rst_i = 1'b0;
    #1;
    n_vec++;
    if ({in_ready_o, wr_valid_o, blk_cnt_o, mb_done_o, wr_addr_o, wr_data_o} !==
        {1'b1, 1'b0, 4'd0, 1'b0, 6'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b blk=%0d done=%b addr=%0d data=%h, want 1 0 0 0 0 0",
               in_ready_o, wr_valid_o, blk_cnt_o, mb_done_o, wr_addr_o, wr_data_o);
    end
  endtask

  // Block 0: pred 100, res 640 -> r=10 -> 110 (0x6E) everywhere.
  task automatic test_single();
    fill(100, 640);
    in_valid_i = 1'b1; wr_ready_i = 1'b1;
    #1;
    n_vec++;
    if (in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got %b want 1", in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    for (int row = 0; row < 4; row++) begin
      n_vec++;
      if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, 6'(4 * row), 32'h6E6E6E6E}) begin
        n_err++;
        $display("FAIL single_row%0d: vld=%b addr=%0d data=%h want 1 %0d 6e6e6e6e",
                 row, wr_valid_o, wr_addr_o, wr_data_o, 4 * row);
      end
      tick();
    end
    n_vec++;
    if ({wr_valid_o, blk_cnt_o} !== {1'b0, 4'd1}) begin
      n_err++; $display("FAIL single_end: vld=%b blk=%0d want 0 1", wr_valid_o, blk_cnt_o);
    end
  endtask

  // Blocks 1..3: saturate high, saturate low, then a mixed-column block.
  task automatic test_clip();
    row_t exp_rows [3][4];
    exp_rows[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_rows[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    exp_rows[2] = '{32'h2140FF00, 32'h3141FF00, 32'h4141FF00, 32'h5142FF00};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        fill(250, 1000); res_a[0] = 15'sd16383;
      end else if (k == 1) begin
        fill(5, -1000); res_a[0] = -15'sd16384;
      end else begin
        for (int r = 0; r < 4; r++) begin
          pred_a[4*r]   = 8'd5;             res_a[4*r]   = -15'sd1000;
          pred_a[4*r+1] = 8'd250;           res_a[4*r+1] = 15'sd1000;
          pred_a[4*r+2] = 8'(8'h40 + r);    res_a[4*r+2] = (r < 2) ? -15'sd32 : -15'sd33;
          pred_a[4*r+3] = 8'(8'h20 + 16*r); res_a[4*r+3] = 15'sd95;
        end
      end
      in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      for (int row = 0; row < 4; row++) begin
        n_vec++;
        if ({wr_valid_o, wr_addr_o, wr_data_o} !==
            {1'b1, 6'(base_addr[k+1] + 4 * row), exp_rows[k][row]}) begin
          n_err++;
          $display("FAIL clip%0d_row%0d: addr=%0d data=%h want %0d %h", k, row,
                   wr_addr_o, wr_data_o, base_addr[k+1] + 4 * row, exp_rows[k][row]);
        end
        tick();
      end
    end
  endtask

  // Block 4 (base 2): stall row 1 for three cycles.
  task automatic test_backpressure();
    row_t exp_rows [4];
    int   row1_writes;
    exp_rows = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
    row1_writes = 0;
    for (int i = 0; i < 16; i++) begin
      pred_a[i] = 8'(16 * (i / 4) + (i % 4));
      res_a[i]  = 15'sd0;
    end
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n_vec++;
    if ({wr_addr_o, wr_data_o} !== {6'd2, exp_rows[0]}) begin
      n_err++; $display("FAIL bp_row0: addr=%0d data=%h want 2 %h", wr_addr_o, wr_data_o, exp_rows[0]);
    end
    tick();
    wr_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if ({wr_valid_o, wr_addr_o, wr_data_o, in_ready_o} !== {1'b1, 6'd6, exp_rows[1], 1'b0}) begin
        n_err++;
        $display("FAIL bp_stall%0d: vld=%b addr=%0d data=%h rdy=%b want 1 6 %h 0",
                 s, wr_valid_o, wr_addr_o, wr_data_o, in_ready_o, exp_rows[1]);
      end
      if (wr_valid_o && wr_ready_i && wr_addr_o == 6'd6) row1_writes++;
      tick();
    end
    wr_ready_i = 1'b1;
    for (int row = 1; row < 4; row++) begin
      n_vec++;
      if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, 6'(2 + 4 * row), exp_rows[row]}) begin
        n_err++;
        $display("FAIL bp_row%0d: addr=%0d data=%h want %0d %h", row,
                 wr_addr_o, wr_data_o, 2 + 4 * row, exp_rows[row]);
      end
      if (wr_valid_o && wr_ready_i && wr_addr_o == 6'd6) row1_writes++;
      tick();
    end
    n_vec++;
    if ({row1_writes == 1, wr_valid_o, blk_cnt_o} !== {1'b1, 1'b0, 4'd5}) begin
      n_err++;
      $display("FAIL bp_end: row1_writes=%0d vld=%b blk=%0d want 1 0 5",
               row1_writes, wr_valid_o, blk_cnt_o);
    end
  endtask

  // mb_start from IDLE, then 16 blocks streamed with no gaps.
  // Block b uses pred=15b, res=64b -> every pixel 16b.
  task automatic test_back_to_back();
    int done_pulses;
    int b;
    int row;
    done_pulses = 0;
    mb_start_i = 1'b1;
    #1;
    n_vec++;
    if (in_ready_o !== 1'b0) begin
      n_err++; $display("FAIL mbstart_ready: got %b want 0", in_ready_o);
    end
    tick();
    mb_start_i = 1'b0;
    n_vec++;
    if (blk_cnt_o !== 4'd0) begin
      n_err++; $display("FAIL mbstart_blk: got %0d want 0", blk_cnt_o);
    end
    fill(0, 0);
    in_valid_i = 1'b1;
    tick();
    for (int w = 0; w < 64; w++) begin
      b   = w / 4;
      row = w % 4;
      if (b < 15) fill(15 * (b + 1), 64 * (b + 1));
      in_valid_i = (b < 15);
      #1;
      n_vec++;
      if ({wr_valid_o, wr_addr_o, wr_data_o, mb_done_o, in_ready_o} !==
          {1'b1, 6'(base_addr[b] + 4 * row), {4{8'(16 * b)}}, 1'b0, row == 3}) begin
        n_err++;
        $display("FAIL b2b_w%0d: vld=%b addr=%0d data=%h done=%b rdy=%b want 1 %0d %h 0 %b",
                 w, wr_valid_o, wr_addr_o, wr_data_o, mb_done_o, in_ready_o,
                 base_addr[b] + 4 * row, {4{8'(16 * b)}}, row == 3);
      end
      if (mb_done_o) done_pulses++;
      tick();
    end
    in_valid_i = 1'b0;
    n_vec++;
    if ({wr_valid_o, mb_done_o, blk_cnt_o} !== {1'b0, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL b2b_done: vld=%b done=%b blk=%0d want 0 1 0", wr_valid_o, mb_done_o, blk_cnt_o);
    end
    if (mb_done_o) done_pulses++;
    tick();
    if (mb_done_o) done_pulses++;
    n_vec++;
    if (done_pulses !== 1) begin
      n_err++; $display("FAIL b2b_pulses: got %0d want 1", done_pulses);
    end
  endtask

  // Abort block 5 at row 2, then check the count restarted at block 0.
  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    fill(0, 0);
    for (int b = 0; b < 5; b++) begin
      in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (mb_done_o) done_seen++;
        tick();
      end
    end
    fill(100, 640);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick(); tick();
    n_vec++;
    if ({wr_valid_o, wr_addr_o, blk_cnt_o} !== {1'b1, 6'd11, 4'd5}) begin
      n_err++;
      $display("FAIL abort_pre: vld=%b addr=%0d blk=%0d want 1 11 5", wr_valid_o, wr_addr_o, blk_cnt_o);
    end
    mb_start_i = 1'b1;
    in_valid_i = 1'b1;
    #1;
    n_vec++;
    if (in_ready_o !== 1'b0) begin
      n_err++; $display("FAIL abort_ready: got %b want 0", in_ready_o);
    end
    tick();
    mb_start_i = 1'b0;
    in_valid_i = 1'b0;
    n_vec++;
    if ({wr_valid_o, blk_cnt_o, mb_done_o} !== {1'b0, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL abort_post: vld=%b blk=%0d done=%b want 0 0 0", wr_valid_o, blk_cnt_o, mb_done_o);
    end
    for (int c = 0; c < 3; c++) begin
      if (mb_done_o) done_seen++;
      tick();
    end
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    for (int row = 0; row < 4; row++) begin
      n_vec++;
      if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, 6'(4 * row), 32'h6E6E6E6E}) begin
        n_err++;
        $display("FAIL abort_row%0d: vld=%b addr=%0d data=%h want 1 %0d 6e6e6e6e",
                 row, wr_valid_o, wr_addr_o, wr_data_o, 4 * row);
      end
      if (mb_done_o) done_seen++;
      tick();
    end
    n_vec++;
    if ({done_seen == 0, blk_cnt_o} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL abort_end: done_seen=%0d blk=%0d want 0 1", done_seen, blk_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clip();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
